// File: rtl/pixel_sensor_controller_pkg.sv
// Shared configuration for the pixel-sensor frame sequencer: array geometry,
// default phase lengths, controller state type and timer sizing helper.
package pixel_sensor_controller_pkg;

    localparam int PIXEL_ARRAY_HEIGHT    = 8;
    localparam int DEFAULT_CODE_BITS     = 8;
    localparam int DEFAULT_ERASE_CYCLES  = 5;
    localparam int DEFAULT_EXPOSE_CYCLES = 255;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_READ
    } pixel_ctrl_state_t;

    // The timer only ever holds "phase length - 1", so clog2 of the longest phase is enough.
    function automatic int timer_width(input int erase_cycles, input int expose_cycles,
                                       input int code_bits);
        int longest;
        longest = 2 ** (code_bits + 1);
        if (erase_cycles > longest) longest = erase_cycles;
        if (expose_cycles > longest) longest = expose_cycles;
        return $clog2(longest);
    endfunction

endpackage

// File: rtl/pixel_sensor_phase_timer.sv
// Loadable down-counter shared by every timed phase; expired flags the last
// cycle of the phase that was loaded.
module pixel_sensor_phase_timer #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/pixel_sensor_controller.sv
// Frame sequencer: drives ERASE/EXPOSE/RAMP through one conversion cycle,
// owns the COUNTER code bus, then offers rows with a valid/ready handshake.
module pixel_sensor_controller
    import pixel_sensor_controller_pkg::*;
#(
    parameter int CODE_BITS     = DEFAULT_CODE_BITS,
    parameter int ROWS          = PIXEL_ARRAY_HEIGHT,
    parameter int ERASE_CYCLES  = DEFAULT_ERASE_CYCLES,
    parameter int EXPOSE_CYCLES = DEFAULT_EXPOSE_CYCLES,
    localparam int ROW_W        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 ERASE,
    output logic                 EXPOSE,
    output logic                 RAMP,
    output logic [CODE_BITS-1:0] COUNTER,
    output logic [ROW_W-1:0]     row_sel,
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic                 frame_done
);

    localparam int TIMER_W        = timer_width(ERASE_CYCLES, EXPOSE_CYCLES, CODE_BITS);
    localparam int CONVERT_CYCLES = 2 ** (CODE_BITS + 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    pixel_ctrl_state_t    state;
    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_value;
    logic                 timer_done;

    pixel_sensor_phase_timer #(
        .WIDTH(TIMER_W)
    ) u_phase_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (timer_load),
        .load_value(timer_value),
        .expired   (timer_done)
    );

    // The timer is reloaded on the edge that enters each timed phase.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    timer_load  = 1'b1;
                    timer_value = TIMER_W'(ERASE_CYCLES - 1);
                end
            end
            S_ERASE: begin
                if (timer_done) begin
                    timer_load  = 1'b1;
                    timer_value = TIMER_W'(EXPOSE_CYCLES - 1);
                end
            end
            S_EXPOSE: begin
                if (timer_done) begin
                    timer_load  = 1'b1;
                    timer_value = TIMER_W'(CONVERT_CYCLES - 1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            ERASE      <= 1'b0;
            EXPOSE     <= 1'b0;
            RAMP       <= 1'b0;
            COUNTER    <= '0;
            row_sel    <= '0;
            row_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_ERASE;
                        busy  <= 1'b1;
                        ERASE <= 1'b1;
                    end
                end
                S_ERASE: begin
                    if (timer_done) begin
                        state  <= S_EXPOSE;
                        ERASE  <= 1'b0;
                        EXPOSE <= 1'b1;
                    end
                end
                S_EXPOSE: begin
                    if (timer_done) begin
                        state   <= S_CONVERT;
                        EXPOSE  <= 1'b0;
                        RAMP    <= 1'b1;
                        COUNTER <= '0;
                    end
                end
                S_CONVERT: begin
                    // RAMP alternates 1/0; the code advances only after the low half.
                    if (timer_done) begin
                        state     <= S_READ;
                        RAMP      <= 1'b0;
                        COUNTER   <= '0;
                        row_valid <= 1'b1;
                        row_sel   <= '0;
                    end else begin
                        RAMP <= ~RAMP;
                        if (!RAMP) begin
                            COUNTER <= COUNTER + 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (row_ready) begin
                        if (row_sel == LAST_ROW) begin
                            state      <= S_IDLE;
                            busy       <= 1'b0;
                            row_valid  <= 1'b0;
                            row_sel    <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            row_sel <= row_sel + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_sensor_controller.sv
// Bench for the pixel-sensor frame sequencer: random scenes and handshakes,
// a phase-level frame scoreboard and a pixel-latch model on the COUNTER bus.
`timescale 1ns/1ps
module tb_pixel_sensor_controller;
    import pixel_sensor_controller_pkg::*;

    localparam int CB    = DEFAULT_CODE_BITS;
    localparam int NROWS = PIXEL_ARRAY_HEIGHT;
    localparam int ER    = DEFAULT_ERASE_CYCLES;
    localparam int EX    = DEFAULT_EXPOSE_CYCLES;
    localparam int CONV  = 2 ** (CB + 1);
    localparam int RW    = $clog2(NROWS);
    localparam int FRAME_BUDGET = 1 + ER + EX + CONV + 40 * NROWS + 100;

    localparam int SCB   = 2;
    localparam int SE    = 1;
    localparam int SX    = 1;
    localparam int SCONV = 2 ** (SCB + 1);

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic row_ready = 1'b0;
    logic busy, erase, expose, ramp, row_valid, frame_done;
    logic [CB-1:0] counter;
    logic [RW-1:0] row_sel;

    logic start_s = 1'b0;
    logic row_ready_s = 1'b1;
    logic busy_s, erase_s, expose_s, ramp_s, row_valid_s, frame_done_s;
    logic [SCB-1:0] counter_s;
    logic [0:0] row_sel_s;

    pixel_sensor_controller dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .ERASE(erase), .EXPOSE(expose), .RAMP(ramp), .COUNTER(counter),
        .row_sel(row_sel), .row_valid(row_valid), .row_ready(row_ready),
        .frame_done(frame_done)
    );

    pixel_sensor_controller #(
        .CODE_BITS(SCB), .ROWS(1), .ERASE_CYCLES(SE), .EXPOSE_CYCLES(SX)
    ) dut_small (
        .clk(clk), .reset(reset), .start(start_s), .busy(busy_s),
        .ERASE(erase_s), .EXPOSE(expose_s), .RAMP(ramp_s), .COUNTER(counter_s),
        .row_sel(row_sel_s), .row_valid(row_valid_s), .row_ready(row_ready_s),
        .frame_done(frame_done_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    int exp_start[$];
    int exp_pix[$];
    int scene[NROWS];
    int latch[NROWS];
    bit tripped[NROWS];

    // Monitor: follows the frame phase by phase and checks durations, codes and rows.
    int ph = 0, run = 0, k = 0, rowi = 0, last_done = -10, want = 0;
    bit done_exp = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            ph = 0;
            run = 0;
            done_exp = 1'b0;
        end else begin
            check("frame_done", frame_done, done_exp);
            if (frame_done) last_done = cyc;
            done_exp = 1'b0;
            if (ph == 2 && !expose) begin
                check("expose_len", run, EX);
                ph = 3;
                k = 0;
            end
            case (ph)
                0: begin
                    if (erase) begin
                        check("frame_expected", exp_start.size() != 0, 1'b1);
                        if (exp_start.size() != 0) begin
                            want = exp_start.pop_front();
                            check("erase_latency", cyc, (want < 0) ? last_done + 1 : want);
                        end
                        check("erase_only", {expose, ramp, busy}, 3'b001);
                        for (int r = 0; r < NROWS; r++) begin
                            tripped[r] = 1'b0;
                            latch[r] = -1;
                        end
                        ph = 1;
                        run = 1;
                    end else begin
                        check("idle_outputs", {busy, expose, ramp, counter, row_valid, row_sel}, '0);
                    end
                end
                1: begin
                    if (erase) begin
                        run++;
                        check("erase_only", {expose, ramp, busy}, 3'b001);
                    end else begin
                        check("erase_len", run, ER);
                        check("expose_rise", {expose, ramp, busy}, 3'b101);
                        ph = 2;
                        run = 1;
                    end
                end
                2: begin
                    run++;
                    check("expose_only", {erase, ramp, busy}, 3'b001);
                end
                3: begin
                    check("convert", {erase, expose, busy, row_valid, ramp, counter},
                          {4'b0010, (k % 2 == 0), CB'(k / 2)});
                    if (ramp) begin
                        for (int r = 0; r < NROWS; r++) begin
                            if (!tripped[r] && int'(counter) >= scene[r]) begin
                                latch[r] = int'(counter);
                                tripped[r] = 1'b1;
                            end
                        end
                    end
                    k++;
                    if (k == CONV) begin
                        ph = 4;
                        rowi = 0;
                    end
                end
                default: begin
                    check("read_row", {erase, expose, ramp, busy, row_valid, counter, row_sel},
                          {3'b000, 1'b1, 1'b1, CB'(0), RW'(rowi)});
                    if (row_ready) begin
                        check("pix_expected", exp_pix.size() != 0, 1'b1);
                        if (exp_pix.size() != 0) check("pixel", latch[rowi], exp_pix.pop_front());
                        rowi++;
                        if (rowi == NROWS) begin
                            ph = 0;
                            done_exp = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_scene();
        for (int r = 0; r < NROWS; r++) scene[r] = int'($urandom_range(0, 2 ** CB - 1));
        scene[0] = 200;
        scene[1] = 0;
        scene[2] = 2 ** CB - 1;
        for (int r = 0; r < NROWS; r++) exp_pix.push_back(scene[r]);
    endtask

    task automatic start_frame();
        new_scene();
        exp_start.push_back(cyc + 1);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int mode);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n < FRAME_BUDGET) begin
            tick();
            n++;
            if (frame_done) got = 1'b1;
            else if (mode == 1) row_ready = 1'($urandom_range(0, 1));
        end
        check(name, got, 1'b1);
    endtask

    function automatic logic [8:0] small_expect(input int i);
        int kk;
        kk = i - SE - SX;
        if (i < SE) return 9'b1_1_0_0_00_0_0_0;
        if (i < SE + SX) return 9'b1_0_1_0_00_0_0_0;
        if (kk < SCONV) return {3'b100, (kk % 2 == 0), SCB'(kk / 2), 3'b000};
        if (kk == SCONV) return 9'b1_0_0_0_00_1_0_0;
        if (kk == SCONV + 1) return 9'b0_0_0_0_00_0_0_1;
        return '0;
    endfunction

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {busy, erase, expose, ramp, counter, row_sel, row_valid, frame_done}, '0);
        check("reset_state_small", {busy_s, erase_s, expose_s, ramp_s, counter_s, row_sel_s,
                                    row_valid_s, frame_done_s}, '0);
        reset = 1'b1;
        repeat (3) tick();

        row_ready = 1'b1;
        start_frame();
        wait_done("frame_ready_high", 0);
        repeat (2) tick();

        start_frame();
        wait_done("frame_random_ready", 1);
        row_ready = 1'b1;
        repeat (2) tick();

        start_frame();
        n = 0;
        while (!(row_valid && row_sel == RW'(2)) && n < FRAME_BUDGET) begin
            tick();
            n++;
        end
        check("bp_reach_row2", {row_valid, row_sel}, {1'b1, RW'(2)});
        row_ready = 1'b0;
        repeat (3) tick();
        check("bp_hold", {row_valid, row_sel}, {1'b1, RW'(2)});
        row_ready = 1'b1;
        tick();
        check("bp_resume", {row_valid, row_sel}, {1'b1, RW'(3)});
        wait_done("bp_done", 0);
        repeat (2) tick();

        new_scene();
        exp_start.push_back(cyc + 1);
        start = 1'b1;
        wait_done("held_frame1", 0);
        new_scene();
        exp_start.push_back(-1);
        tick();
        start = 1'b0;
        check("held_restart", {erase, busy}, 2'b11);
        wait_done("held_frame2", 0);
        repeat (2) tick();

        start_frame();
        n = 0;
        while (!(ramp && counter == CB'(100)) && n < FRAME_BUDGET) begin
            tick();
            n++;
        end
        check("reached_code100", {ramp, counter}, {1'b1, CB'(100)});
        #2 reset = 1'b0;
        #1;
        check("async_reset_outputs", {busy, erase, expose, ramp, counter, row_sel, row_valid,
                                      frame_done}, '0);
        exp_pix.delete();
        repeat (2) tick();
        reset = 1'b1;
        repeat (5) tick();
        check("idle_after_reset", {busy, erase}, 2'b00);

        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int i = 0; i < 14; i++) begin
            check("small_sequence", {busy_s, erase_s, expose_s, ramp_s, counter_s, row_valid_s,
                                     row_sel_s, frame_done_s}, small_expect(i));
            tick();
        end

        start_frame();
        wait_done("frame_after_reset", 1);
        row_ready = 1'b1;
        repeat (3) tick();
        check("start_queue_empty", exp_start.size(), 0);
        check("pix_queue_empty", exp_pix.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
